// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with IDLE/BUSY data-memory handshake, ack timeout and optional MEM_STAGE_ALIGN_CHECK_EN misalignment abort
module mem_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  WB,
    input  logic [2:0]  M,
    input  logic [31:0] PC,
    input  logic        zero,
    input  logic [31:0] ALUresult,
    input  logic [31:0] writeData,
    input  logic [4:0]  writeRegister,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] branch_target,
    output logic [1:0]  WB_output,
    output logic [31:0] readData_output,
    output logic [31:0] ALUresult_output,
    output logic [4:0]  writeRegister_output,
    output logic        mem_err
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [7:0] LP_LAST = 8'(ACK_TIMEOUT - 1);
    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic        r_mem_req, r_mem_we, r_mem_err;
    logic [31:0] r_mem_addr, r_mem_wdata, r_rdata, r_alu;
    logic [1:0]  r_wb;
    logic [4:0]  r_wreg;
    logic        w_memop, w_misalign, w_busy, w_abort, w_capture, w_hold;
    assign w_memop = M[1] | M[0];
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign w_misalign = ALUresult[1:0] != 2'b00;
`else
    assign w_misalign = 1'b0;
`endif
    assign w_busy = r_state == BUSY;
    // w_hold: stay in (or enter) BUSY; a timeout releases the pipeline in its final cycle
    always_comb begin
        w_abort   = w_busy ? (!mem_ack && r_cnt == LP_LAST) : (w_memop && w_misalign);
        w_capture = w_busy ? mem_ack : !w_memop;
        w_hold    = w_busy ? (!mem_ack && !w_abort) : (w_memop && !w_misalign);
        w_next    = w_hold ? BUSY : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_err   <= 1'b0;
            r_wb        <= '0;
            r_rdata     <= '0;
            r_alu       <= '0;
            r_wreg      <= '0;
        end else begin
            r_cnt       <= w_busy ? r_cnt + 8'd1 : 8'd0;
            r_mem_req   <= w_hold;
            r_mem_we    <= w_hold & M[0];
            r_mem_addr  <= (!w_busy && w_hold) ? ALUresult : r_mem_addr;
            r_mem_wdata <= (!w_busy && w_hold) ? writeData : r_mem_wdata;
            r_mem_err   <= w_abort;
            r_wb        <= w_capture ? WB : 2'b00;
            r_rdata     <= (w_capture && w_busy && !M[0]) ? mem_rdata : 32'd0;
            r_alu       <= w_capture ? ALUresult : 32'd0;
            r_wreg      <= w_capture ? writeRegister : 5'd0;
        end
    end
    assign stall                = rst_n & w_hold;
    assign PCSrc                = rst_n & M[2] & zero & !stall;
    assign branch_target        = PC;
    assign mem_req              = r_mem_req;
    assign mem_we               = r_mem_we;
    assign mem_addr             = r_mem_addr;
    assign mem_wdata            = r_mem_wdata;
    assign mem_err              = r_mem_err;
    assign WB_output            = r_wb;
    assign readData_output      = r_rdata;
    assign ALUresult_output     = r_alu;
    assign writeRegister_output = r_wreg;
endmodule
